// File: rtl/mau_pkg.sv
// Shared types and defaults for the load/store front end (mem_access_unit).
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  localparam logic [31:0] DM_BASE_DEF  = 32'h1001_0000;
  localparam int unsigned DM_BYTES_DEF = 1024;

  // True when the size code is illegal or the offset does not suit the size.
  function automatic logic size_addr_bad(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: load extract with sign/zero extension and store lane merge.
module mem_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] merged
);

  logic [4:0]  shift_b;
  logic [4:0]  shift_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] mask_b;
  logic [31:0] mask_h;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
  always_comb begin
    shift_b   = {~offset, 3'b000};
    shift_h   = {~offset[1], 4'b0000};
    lane_b    = 8'(word >> shift_b);
    lane_h    = 16'(word >> shift_h);
    mask_b    = 32'h0000_00FF << shift_b;
    mask_h    = 32'h0000_FFFF << shift_h;
    rdata_ext = word;
    merged    = wdata;
    case (size)
      SZ_B: begin
        rdata_ext = {{24{sign_ext & lane_b[7]}}, lane_b};
        merged    = (word & ~mask_b) | ((32'(wdata[7:0]) << shift_b) & mask_b);
      end
      SZ_H: begin
        rdata_ext = {{16{sign_ext & lane_h[15]}}, lane_h};
        merged    = (word & ~mask_h) | ((32'(wdata[15:0]) << shift_h) & mask_h);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: FSM, request latches, range/alignment check, counters.
// Optional performance counters enabled by defining MAU_PERF_CNT_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = DM_BASE_DEF,
  parameter int unsigned DM_BYTES = DM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_wr,
  input  logic [31:0] dm_rdata,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_store,
  output logic [31:0] cnt_err
);

  state_e      state_reg, state_next;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        sign_reg;
  logic [1:0]  off_reg;
  logic [31:0] wdata_reg;
  logic [31:0] dm_addr_reg;
  logic [31:0] dm_wdata_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic [31:0] req_off;
  logic        req_err;
  logic [31:0] rdata_ext;
  logic [31:0] merged;

  // Below-base addresses wrap to huge offsets, so one unsigned compare covers both ends.
  assign req_off = req_addr - DM_BASE;
  assign req_err = size_addr_bad(req_size, req_addr[1:0]) || (req_off >= DM_BYTES);

  mem_lane_align u_align (
    .offset    (off_reg),
    .size      (size_reg),
    .sign_ext  (sign_reg),
    .word      (dm_rdata),
    .wdata     (wdata_reg),
    .rdata_ext (rdata_ext),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) begin
        if (req_err)             state_next = RESP;
        else if (!req_we)        state_next = RD;
        else if (req_size == SZ_W) state_next = WR;
        else                     state_next = RD;
      end
      RD:      state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == RESP);
    dm_wr      = (state_reg == WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg         <= 1'b0;
      size_reg       <= 2'b00;
      sign_reg       <= 1'b0;
      off_reg        <= 2'b00;
      wdata_reg      <= '0;
      dm_addr_reg    <= '0;
      dm_wdata_reg   <= '0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          we_reg       <= req_we;
          size_reg     <= req_size;
          sign_reg     <= req_signed;
          off_reg      <= req_addr[1:0];
          wdata_reg    <= req_wdata;
          resp_err_reg <= req_err;
          if (!req_err) begin
            dm_addr_reg <= {req_addr[31:2], 2'b00};
            if (req_we && req_size == SZ_W) dm_wdata_reg <= req_wdata;
          end
        end
        // dm_rdata is valid at the end of RD: capture the load result or the merged store word.
        RD: begin
          if (we_reg) dm_wdata_reg   <= merged;
          else        resp_rdata_reg <= rdata_ext;
        end
        RESP: begin
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign dm_addr    = dm_addr_reg;
  assign dm_wdata   = dm_wdata_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;

`ifdef MAU_PERF_CNT_EN
  logic [31:0] cnt_load_reg, cnt_store_reg, cnt_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_load_reg  <= '0;
      cnt_store_reg <= '0;
      cnt_err_reg   <= '0;
    end else if (state_reg == RESP) begin
      if (resp_err_reg)  cnt_err_reg   <= cnt_err_reg + 32'd1;
      else if (we_reg)   cnt_store_reg <= cnt_store_reg + 32'd1;
      else               cnt_load_reg  <= cnt_load_reg + 32'd1;
    end
  end

  assign cnt_load  = cnt_load_reg;
  assign cnt_store = cnt_store_reg;
  assign cnt_err   = cnt_err_reg;
`else
  assign cnt_load  = 32'h0;
  assign cnt_store = 32'h0;
  assign cnt_err   = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wr;
  logic [31:0] dm_rdata;
  logic [31:0] cnt_load, cnt_store, cnt_err;

  int checks = 0;
  int errors = 0;
  int exp_load = 0, exp_store = 0, exp_err = 0;

  logic        mem_init;
  logic [31:0] dm_mem [0:255];
  logic [31:0] dm_off;
  logic [7:0]  ref_mem [0:BYTES-1];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wr(dm_wr), .dm_rdata(dm_rdata),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_err(cnt_err)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
  endfunction

  // Data memory: combinational read, word write at posedge.
  assign dm_off   = dm_addr - BASE;
  assign dm_rdata = dm_mem[dm_off[9:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dm_mem[i] <= init_word(i);
    end else if (dm_wr) begin
      dm_mem[dm_off[9:2]] <= dm_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] off);
    logic [31:0] o;
    o = {off[31:2], 2'b00};
    return {ref_mem[o], ref_mem[o+1], ref_mem[o+2], ref_mem[o+3]};
  endfunction

  // Reference model: plain byte-array memory, applies the access and predicts the response.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
    logic [31:0] off, val;
    int n;
    off = a - BASE;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % n) != 0) || (a < BASE) || (a >= BASE + BYTES);
    rd  = 32'h0;
    if (err) begin
      lat = 1;
      exp_err++;
    end else if (!we) begin
      lat = 2;
      val = 32'h0;
      for (int k = 0; k < n; k++) val = (val << 8) | 32'(ref_mem[off + k]);
      if (n < 4 && sg && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
      rd = val;
      exp_load++;
    end else begin
      lat = (n == 4) ? 2 : 3;
      for (int k = 0; k < n; k++) ref_mem[off + k] = 8'(wd >> (8 * (n - 1 - k)));
      exp_store++;
    end
  endtask

  task automatic present(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
  endtask

  task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got_rd, output logic [31:0] got_wr);
    logic e, done;
    logic [31:0] rd, exp_word;
    int lat, got_lat, wr_n;
    model(we, sz, sg, a, wd, e, rd, lat);
    exp_word = e ? 32'h0 : ref_word(a - BASE);
    got_rd = 32'h0; got_wr = 32'h0;
    @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'h1);
    present(we, sz, sg, a, wd);
    @(posedge clk);
    got_lat = 0; wr_n = 0; done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      got_lat++;
      if (dm_wr) begin
        wr_n++;
        got_wr = dm_wdata;
        check("dm_addr_in_wr", dm_addr, {a[31:2], 2'b00});
      end
      if (resp_valid) begin
        done = 1'b1;
        got_rd = resp_rdata;
        check("resp_err", 32'(resp_err), 32'(e));
        check("resp_rdata", resp_rdata, rd);
      end
    end
    check("resp_seen", 32'(done), 32'h1);
    check("latency", 32'(got_lat), 32'(lat));
    check("dm_wr_pulses", 32'(wr_n), (we && !e) ? 32'h1 : 32'h0);
    if (we && !e) check("dm_wdata", got_wr, exp_word);
    $display("op we=%0d sz=%0d sg=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             we, sz, sg, a, wd, e, got_rd, got_lat);
  endtask

  task automatic check_counters(input string tag);
    logic [31:0] cl, cs, ce;
`ifdef MAU_PERF_CNT_EN
    cl = 32'(exp_load); cs = 32'(exp_store); ce = 32'(exp_err);
`else
    cl = 32'h0; cs = 32'h0; ce = 32'h0;
`endif
    check({tag, "_cnt_load"}, cnt_load, cl);
    check({tag, "_cnt_store"}, cnt_store, cs);
    check({tag, "_cnt_err"}, cnt_err, ce);
  endtask

  initial begin
    logic [31:0] rd, wr;
    logic        b_we [4];
    logic [1:0]  b_sz [4];
    logic        b_sg [4];
    logic [31:0] b_a  [4];
    logic [31:0] b_wd [4];
    logic        q_err [$];
    logic [31:0] q_rd  [$];
    int          nxt, got, bad, extra;
    logic        e, accepted;
    int          lat;

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      wr = init_word(i);
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = 8'(wr >> (8 * (3 - k)));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    // Reset values
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_dm_wr", 32'(dm_wr), 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    check_counters("rst");

    // Reset held 2 cycles while a load sits in RD: dropped, no response
    present(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrd_ready", 32'(req_ready), 32'h1);
    check("midrd_dm_wr", 32'(dm_wr), 32'h0);
    check("midrd_resp_valid", 32'(resp_valid), 32'h0);
    check("midrd_dm_addr", dm_addr, 32'h0);
    check_counters("midrd");
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || dm_wr) extra++;
    end
    check("midrd_no_resp", 32'(extra), 32'h0);

    // Word store then load
    do_op(1'b1, 2'd2, 1'b0, 32'h1001_0010, 32'hDEAD_BEEF, rd, wr);
    check("t2_sw_wdata", wr, 32'hDEAD_BEEF);
    do_op(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, rd, wr);
    check("t2_lw", rd, 32'hDEAD_BEEF);

    // Byte store and loads
    do_op(1'b1, 2'd0, 1'b0, 32'h1001_0011, 32'h0000_005A, rd, wr);
    check("t3_sb_wdata", wr, 32'hDE5A_BEEF);
    do_op(1'b0, 2'd0, 1'b1, 32'h1001_0011, 32'h0, rd, wr);
    check("t3_lb_11", rd, 32'h0000_005A);
    do_op(1'b0, 2'd0, 1'b1, 32'h1001_0010, 32'h0, rd, wr);
    check("t3_lb_10", rd, 32'hFFFF_FFDE);
    do_op(1'b0, 2'd0, 1'b0, 32'h1001_0010, 32'h0, rd, wr);
    check("t3_lbu_10", rd, 32'h0000_00DE);

    // Half store and loads
    do_op(1'b1, 2'd1, 1'b0, 32'h1001_0012, 32'h0000_8001, rd, wr);
    check("t4_sh_wdata", wr, 32'hDE5A_8001);
    do_op(1'b0, 2'd1, 1'b1, 32'h1001_0012, 32'h0, rd, wr);
    check("t4_lh", rd, 32'hFFFF_8001);
    do_op(1'b0, 2'd1, 1'b0, 32'h1001_0012, 32'h0, rd, wr);
    check("t4_lhu", rd, 32'h0000_8001);

    // Error cases
    do_op(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0, rd, wr);
    do_op(1'b0, 2'd1, 1'b1, 32'h1001_0001, 32'h0, rd, wr);
    do_op(1'b1, 2'd2, 1'b0, 32'h1001_0400, 32'h1234_5678, rd, wr);
    do_op(1'b1, 2'd3, 1'b0, 32'h1001_0010, 32'hFFFF_FFFF, rd, wr);
    do_op(1'b0, 2'd0, 1'b0, 32'h1000_FFFF, 32'h0, rd, wr);
    do_op(1'b0, 2'd2, 1'b0, 32'h1001_03FC, 32'h0, rd, wr);

    // Back-to-back with req_valid held high
    b_we[0] = 1'b1; b_sz[0] = 2'd2; b_sg[0] = 1'b0; b_a[0] = BASE + 32'h20; b_wd[0] = 32'h1122_3344;
    b_we[1] = 1'b0; b_sz[1] = 2'd0; b_sg[1] = 1'b0; b_a[1] = BASE + 32'h21; b_wd[1] = 32'h0;
    b_we[2] = 1'b1; b_sz[2] = 2'd0; b_sg[2] = 1'b0; b_a[2] = BASE + 32'h23; b_wd[2] = 32'h0000_00C7;
    b_we[3] = 1'b0; b_sz[3] = 2'd2; b_sg[3] = 1'b0; b_a[3] = BASE + 32'h03; b_wd[3] = 32'h0;
    nxt = 0; got = 0;
    @(negedge clk);
    present(b_we[0], b_sz[0], b_sg[0], b_a[0], b_wd[0]);
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (resp_valid) begin
        check("b2b_err", 32'(resp_err), 32'(q_err.pop_front()));
        check("b2b_rdata", resp_rdata, q_rd.pop_front());
        $display("b2b resp %0d err=%0d rdata=%h", got, resp_err, resp_rdata);
        got++;
      end
      accepted = 1'b0;
      if (req_valid && req_ready) begin
        model(b_we[nxt], b_sz[nxt], b_sg[nxt], b_a[nxt], b_wd[nxt], e, rd, lat);
        q_err.push_back(e);
        q_rd.push_back(rd);
        nxt++;
        accepted = 1'b1;
      end
      @(negedge clk);
      if (accepted) begin
        if (nxt < 4) present(b_we[nxt], b_sz[nxt], b_sg[nxt], b_a[nxt], b_wd[nxt]);
        else req_valid = 1'b0;
      end
    end
    check("b2b_resp_count", 32'(got), 32'h4);
    req_valid = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    check("b2b_no_extra_resp", 32'(extra), 32'h0);
    check_counters("b2b");

    // Randomized accesses in a small window plus occasional out-of-range
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      case ($urandom_range(0, 9))
        0:       a = BASE + BYTES + 32'($urandom_range(0, 7));
        1:       a = BASE - 32'($urandom_range(1, 4));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, wr);
    end
    check_counters("final");

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dm_mem[i] !== ref_word(32'(4 * i))) bad++;
    check("memory_image", 32'(bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
